// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause 22 MDIO PHY-side responder with a 32x16 register file.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int          PREAMBLE_MIN = 32,
    parameter logic [15:0] REG0_RST     = 16'h1140,
    parameter logic [15:0] PHY_ID1      = 16'h001C,
    parameter logic [15:0] PHY_ID2      = 16'hC915
) (
    input  logic        mdc,
    input  logic        reset_n,
    inout  wire         mdio,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [15:0] ctrl_reg,
    output logic        frame_err
);
    typedef enum logic [2:0] {IDLE, START, OP, PHYAD, REGAD, TA, DATA} state_t;
    state_t      state, next_state;
    logic [3:0]  bit_cnt;
    logic [5:0]  pre_cnt;
    logic        op_b0, op_rd, match, ta_b0, ta_ok;
    logic [3:0]  phy_sh;
    logic [4:0]  reg_addr;
    logic [14:0] data_sh;
    logic [15:0] rd_shift;
    logic [15:0] regs [32];
    logic        oe, o;
    logic        pre_ok, op_err, ta_err, commit, soft_rst, rd_active, rd_latch;
    logic [15:0] rd_word, wr_word;
    assign mdio     = oe ? o : 1'bz;
    assign ctrl_reg = regs[0];
    always_ff @(posedge mdc or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (!mdio && pre_ok) ? START : IDLE;
            START:   next_state = mdio ? OP : IDLE;
            OP:      next_state = !bit_cnt[0] ? OP : (op_b0 != mdio) ? PHYAD : IDLE;
            PHYAD:   next_state = (bit_cnt == 4'd4) ? REGAD : PHYAD;
            REGAD:   next_state = (bit_cnt == 4'd4) ? TA : REGAD;
            TA:      next_state = bit_cnt[0] ? DATA : TA;
            DATA:    next_state = (bit_cnt == 4'd15) ? IDLE : DATA;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        pre_ok    = int'(pre_cnt) >= PREAMBLE_MIN;
        op_err    = (state == START && !mdio) || (state == OP && bit_cnt[0] && op_b0 == mdio);
        ta_err    = state == TA && bit_cnt[0] && !op_rd && !(ta_b0 && !mdio);
        wr_word   = {data_sh, mdio};
        commit    = state == DATA && bit_cnt == 4'd15 && !op_rd && ta_ok && match
                    && reg_addr != 5'd2 && reg_addr != 5'd3;
        soft_rst  = commit && reg_addr == 5'd0 && wr_word[15];
        rd_active = op_rd && match;
        rd_latch  = rd_active && state == TA && !bit_cnt[0];
        rd_word   = (reg_addr == 5'd2) ? PHY_ID1 : (reg_addr == 5'd3) ? PHY_ID2 : regs[reg_addr];
    end
    always_ff @(posedge mdc or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            pre_cnt   <= '0;
            op_b0     <= 1'b0;
            op_rd     <= 1'b0;
            phy_sh    <= '0;
            match     <= 1'b0;
            reg_addr  <= '0;
            ta_b0     <= 1'b0;
            ta_ok     <= 1'b0;
            data_sh   <= '0;
            rd_shift  <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? REG0_RST : 16'h0;
        end else begin
            bit_cnt   <= (next_state != state || state == IDLE) ? 4'd0 : bit_cnt + 4'd1;
            // preamble count only accumulates while idle; any frame activity forces a fresh preamble
            pre_cnt   <= (state != IDLE || !mdio) ? 6'd0 : pre_cnt + {5'd0, pre_cnt != 6'd63};
            if (state == OP && !bit_cnt[0]) op_b0 <= mdio;
            if (state == OP && bit_cnt[0]) op_rd <= op_b0;
            if (state == PHYAD) phy_sh <= {phy_sh[2:0], mdio};
            if (state == PHYAD && bit_cnt == 4'd4) match <= {phy_sh, mdio} == PHY_ADDR;
            if (state == REGAD) reg_addr <= {reg_addr[3:0], mdio};
            if (state == TA && !bit_cnt[0]) ta_b0 <= mdio;
            if (state == TA && bit_cnt[0]) ta_ok <= ta_b0 && !mdio;
            if (state == DATA) data_sh <= {data_sh[13:0], mdio};
            if (rd_latch) rd_shift <= rd_word;
            wr_strobe <= commit;
            frame_err <= op_err || ta_err;
            if (commit) begin
                wr_addr <= reg_addr;
                wr_data <= wr_word;
            end
            if (soft_rst) for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? REG0_RST : 16'h0;
            else if (commit) regs[reg_addr] <= wr_word;
        end
    end
    // drive on falling edges: TA bit1 as 0, then D15..D0 indexed by the posedge bit counter
    always_ff @(negedge mdc or negedge reset_n) begin
        if (!reset_n) begin
            oe <= 1'b0;
            o  <= 1'b0;
        end else begin
            oe <= rd_active && ((state == TA && bit_cnt[0]) || state == DATA);
            o  <= state == DATA && rd_shift[~bit_cnt];
        end
    end
endmodule
